// File: rtl/iterative_shift_sequencer_if.sv
// Request/result bundle for iterative_shift_sequencer.
//   up_valid/up_ready    request handshake (requester -> shifter)
//   up_data              operand, N bits
//   up_amount            shift distance, W bits
//   up_dir               0 = left, 1 = right
//   up_arith             right shifts only: fill with operand MSB
//   down_valid/down_ready result handshake (shifter -> consumer)
//   down_data            shifted result, N bits
//   busy                 shifter is working or holding a result
// The slave modport is the shifter side; master is the requester/consumer side.
interface iterative_shift_sequencer_if #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) ();
    logic         up_valid;
    logic         up_ready;
    logic [N-1:0] up_data;
    logic [W-1:0] up_amount;
    logic         up_dir;
    logic         up_arith;
    logic         down_valid;
    logic         down_ready;
    logic [N-1:0] down_data;
    logic         busy;

    modport slave (
        input  up_valid, up_data, up_amount, up_dir, up_arith, down_ready,
        output up_ready, down_valid, down_data, busy
    );

    modport master (
        output up_valid, up_data, up_amount, up_dir, up_arith, down_ready,
        input  up_ready, down_valid, down_data, busy
    );
endinterface

// File: rtl/iterative_shift_sequencer.sv
// Multi-cycle variable shifter. One shift stage is reused W times per
// operation; stage k shifts by 2**k when bit k of the captured amount is set.
// Latency is a fixed W edges from accept to down_valid.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-high reset
//   bus  slave side of iterative_shift_sequencer_if (request in, result out)
module iterative_shift_sequencer #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic                          clk,
    input  logic                          rst,
    iterative_shift_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [W-1:0] K_LAST = W'(W - 1);

    state_t         state_q;
    logic [W-1:0]   k_q;
    logic [W-1:0]   amount_q;
    logic           dir_q;
    logic           fill_q;
    logic [N-1:0]   work_q;
    logic [N-1:0]   down_data_q;

    logic [N-1:0]   stage_d;
    logic [W:0]     dist_s;
    logic [2*N-1:0] ext_s;
    logic           amt_bit_s;

    // One shift stage: distance 2**k, right shifts pull fill bits in from the
    // upper half of the extended word, every result truncated to N bits.
    always_comb begin
        dist_s    = (W+1)'(1) << k_q;
        ext_s     = {{N{fill_q}}, work_q} >> dist_s;
        amt_bit_s = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (k_q == W'(i)) begin
                amt_bit_s = amount_q[i];
            end else begin
                amt_bit_s = amt_bit_s;
            end
        end
        if (amt_bit_s) begin
            if (dir_q) begin
                stage_d = ext_s[N-1:0];
            end else begin
                stage_d = work_q << dist_s;
            end
        end else begin
            stage_d = work_q;
        end
    end

    // Control FSM plus operand capture, stage iteration and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            amount_q    <= '0;
            dir_q       <= 1'b0;
            fill_q      <= 1'b0;
            work_q      <= '0;
            down_data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.up_valid) begin
                        work_q   <= bus.up_data;
                        amount_q <= bus.up_amount;
                        dir_q    <= bus.up_dir;
                        // Fill is resolved once: only arithmetic right shifts of a
                        // negative operand bring in ones.
                        fill_q   <= bus.up_arith & bus.up_dir & bus.up_data[N-1];
                        k_q      <= '0;
                        state_q  <= S_SHIFT;
                    end else begin
                        state_q  <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    work_q <= stage_d;
                    k_q    <= k_q + W'(1);
                    if (k_q == K_LAST) begin
                        down_data_q <= stage_d;
                        state_q     <= S_DONE;
                    end else begin
                        state_q     <= S_SHIFT;
                    end
                end
                S_DONE: begin
                    if (bus.down_ready) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.up_ready   = (state_q == S_IDLE);
    assign bus.down_valid = (state_q == S_DONE);
    assign bus.busy       = (state_q == S_SHIFT) || (state_q == S_DONE);
    assign bus.down_data  = down_data_q;

endmodule
